sipo_shift_rx: RTL

- Serial-in/parallel-out receiver; the deserialising end of the team's PISO shift-register path (mux_2-based PISO loads and shifts words out serially).
- Samples one bit per enabled clock, assembles a WIDTH-bit word, and presents it on a valid/ready parallel handshake.
- Flags overrun when the consumer is too slow.
- Sits between the serial link and the parallel datapath/register file.

---
 rtl/sipo_shift_rx_if.sv | 26 ++
 rtl/sipo_shift_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sipo_shift_rx_if.sv
// rtl/sipo_shift_rx_if.sv - serial-in and parallel handshake bundle for sipo_shift_rx
interface sipo_shift_rx_if #(
  parameter int WIDTH = 8
);
  logic             serial_in;
  logic             shift_en;
  logic             frame_start;
  logic             par_ready;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  // receiver side: consumes serial bits and ready, produces the parallel word
  modport master (
    input  serial_in, shift_en, frame_start, par_ready,
    output par_out, par_valid, busy, overrun, parity_err
  );

  // link/consumer side
  modport slave (
    output serial_in, shift_en, frame_start, par_ready,
    input  par_out, par_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_shift_rx.sv
// rtl/sipo_shift_rx.sv - serial-in/parallel-out word receiver, optional even parity via SIPO_PARITY_EN
module sipo_shift_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  sipo_shift_rx_if.master bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;
  logic             load;
  logic [WIDTH-1:0] load_word;

`ifdef SIPO_PARITY_EN
  logic perr_q, perr_d;
  logic load_perr;
`endif

  // next shift-register image: a frame_start bit always begins from an empty register
  always_comb begin
    shift_base = bus.frame_start ? '0 : sr_q;
    if (MSB_FIRST)
      shifted = {shift_base[WIDTH-2:0], bus.serial_in};
    else
      shifted = {bus.serial_in, shift_base[WIDTH-1:1]};
  end

  // state register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // frame FSM: bit capture, resync on frame_start, word completion
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_word = shifted;
`ifdef SIPO_PARITY_EN
    load_perr = 1'b0;
`endif
    if (bus.shift_en) begin
      case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            sr_d    = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.frame_start) begin
            sr_d  = shifted;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            sr_d = shifted;
`ifdef SIPO_PARITY_EN
            cnt_d   = CW'(WIDTH);
            state_d = PARITY;
`else
            load    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (bus.frame_start) begin
            sr_d    = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            load      = 1'b1;
            load_word = sr_q;
            load_perr = (^sr_q) != bus.serial_in;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // parallel handshake: a completing word always loads; overrun if the old one was not taken
  always_comb begin
    par_d   = load ? load_word : par_q;
    valid_d = load | (valid_q & ~bus.par_ready);
    ovr_d   = load & valid_q & ~bus.par_ready;
`ifdef SIPO_PARITY_EN
    perr_d  = load ? load_perr : perr_q;
`endif
  end

  assign bus.par_out    = par_q;
  assign bus.par_valid  = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
